// File: rtl/mem_pkg.sv
// Shared constants and types for the core-to-mainmem port arbiter.
package mem_pkg;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [31:0] MEM_BASE_DEFAULT  = 32'h0100_0000;
  localparam logic [31:0] MEM_DEPTH_DEFAULT = 32'h0010_0000;

  typedef enum logic {ST_IDLE, ST_RMW_WR} arb_state_t;

  // Legal when naturally aligned for its size and the containing word lies inside memory.
  function automatic logic addr_ok(input logic [31:0] addr, input logic [1:0] size,
                                   input logic [31:0] base, input logic [31:0] depth);
    logic [31:0] word_addr;
    logic        aligned;
    word_addr = {addr[31:2], 2'b00};
    case (size)
      SIZE_BYTE: aligned = 1'b1;
      SIZE_HALF: aligned = ~addr[0];
      SIZE_WORD: aligned = (addr[1:0] == 2'b00);
      default:   aligned = 1'b0;
    endcase
    return aligned && (word_addr >= base) && (word_addr <= base + depth - 32'd4);
  endfunction

endpackage

// File: rtl/lane_merge.sv
// Byte/half lane handling: merges store data into a read word and extracts/extends load data.
module lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] store_data,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    merged    = word;
    load_data = word;
    byte_val  = word[{lane, 3'b000} +: 8];
    half_val  = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SIZE_BYTE: begin
        merged[{lane, 3'b000} +: 8] = store_data[7:0];
        load_data = zero_ext ? {24'd0, byte_val} : {{24{byte_val[7]}}, byte_val};
      end
      SIZE_HALF: begin
        merged[{lane[1], 4'b0000} +: 16] = store_data[15:0];
        load_data = zero_ext ? {16'd0, half_val} : {{16{half_val[15]}}, half_val};
      end
      default: merged = store_data;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store ports onto single-port mainmem; sub-word stores use read-modify-write.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter logic [31:0] MEM_BASE        = MEM_BASE_DEFAULT,
  parameter logic [31:0] MEM_DEPTH_BYTES = MEM_DEPTH_DEFAULT,
  parameter int          STARVE_LIMIT    = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_address,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_error,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_address,
  input  logic        d_read_write,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_data_in,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_read_write
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;
  logic [31:0]      rmw_address;
  logic [31:0]      rmw_data;
  logic             starved, if_accept, d_accept, if_err, d_err, d_sub_store;
  logic [31:0]      merged, load_data;

  lane_merge u_lane_merge (
    .word       (mem_data_out),
    .store_data (d_data_in),
    .lane       (d_address[1:0]),
    .size       (d_size),
    .zero_ext   (d_unsigned),
    .merged     (merged),
    .load_data  (load_data)
  );

  always_comb begin
    starved      = (starve_cnt == CNT_MAX);
    if_req_ready = (state == ST_IDLE) && if_req_valid && (!d_req_valid || starved);
    d_req_ready  = (state == ST_IDLE) && d_req_valid && !(if_req_valid && starved);
    if_accept    = if_req_valid && if_req_ready;
    d_accept     = d_req_valid && d_req_ready;
    if_err       = !addr_ok(if_address, SIZE_WORD, MEM_BASE, MEM_DEPTH_BYTES);
    d_err        = !addr_ok(d_address, d_size, MEM_BASE, MEM_DEPTH_BYTES);
    d_sub_store  = (d_read_write == WRITE) && (d_size != SIZE_WORD);

    // Idle bus parks on MEM_BASE; rejected requests never reach memory.
    mem_address    = MEM_BASE;
    mem_read_write = READ;
    mem_data_in    = 32'd0;
    if (state == ST_RMW_WR) begin
      mem_address    = rmw_address;
      mem_read_write = WRITE;
      mem_data_in    = rmw_data;
    end else if (if_accept && !if_err) begin
      mem_address = {if_address[31:2], 2'b00};
    end else if (d_accept && !d_err) begin
      mem_address = {d_address[31:2], 2'b00};
      if (d_read_write == WRITE && d_size == SIZE_WORD) begin
        mem_read_write = WRITE;
        mem_data_in    = d_data_in;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      starve_cnt   <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_error <= 1'b0;
      if_rsp_data  <= 32'd0;
      d_rsp_valid  <= 1'b0;
      d_rsp_error  <= 1'b0;
      d_rsp_data   <= 32'd0;
    end else begin
      if_rsp_valid <= if_accept;
      if_rsp_error <= if_accept && if_err;
      if_rsp_data  <= (if_accept && !if_err) ? mem_data_out : 32'd0;
      d_rsp_valid  <= 1'b0;
      d_rsp_error  <= 1'b0;
      d_rsp_data   <= 32'd0;
      case (state)
        ST_IDLE: begin
          if (if_accept)
            starve_cnt <= '0;
          else if (d_accept && if_req_valid && !starved)
            starve_cnt <= starve_cnt + CNT_W'(1);
          if (d_accept) begin
            if (d_err) begin
              d_rsp_valid <= 1'b1;
              d_rsp_error <= 1'b1;
            end else if (d_sub_store) begin
              state <= ST_RMW_WR;
            end else begin
              d_rsp_valid <= 1'b1;
              if (d_read_write == READ) d_rsp_data <= load_data;
            end
          end
        end
        ST_RMW_WR: begin
          state       <= ST_IDLE;
          d_rsp_valid <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Merged word is captured in the read cycle and written back in ST_RMW_WR.
  always_ff @(posedge clock) begin
    if (state == ST_IDLE && d_accept && !d_err && d_sub_store) begin
      rmw_address <= {d_address[31:2], 2'b00};
      rmw_data    <= merged;
    end
  end

endmodule
